// File: rtl/diff_pkg.sv
// diff_pkg: shared types and helpers for the differential DNA-word encoder
// and its round-robin front end.
//   digit_t      - one 2-bit DNA digit
//   arb_state_t  - scheduler FSM states (IDLE, ENC, DONE)
//   mod4_sub     - (cur - prev) mod 4 for the differential encode
package diff_pkg;

  typedef logic [1:0] digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  // The difference is formed in 3 bits so a borrow cannot wrap into
  // anything but the discarded top bit; keeping the low 2 bits gives the
  // mod-4 result (0-3 -> 1, 1-3 -> 2).
  function automatic digit_t mod4_sub(input digit_t cur, input digit_t prev);
    return digit_t'({1'b0, cur} - {1'b0, prev});
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant picker.
//   req     - request vector, one bit per requester
//   ptr     - index that has highest priority this arbitration
//   en      - when low, no grant is issued
//   gnt     - one-hot grant (all zero when en=0 or no request)
//   gnt_idx - binary index of the granted requester (0 when none)
// Search order is ptr, ptr+1, ..., R-1, 0, ..., ptr-1.
module rr_arbiter #(
  parameter int R   = 4,
  parameter int IDW = $clog2(R)
) (
  input  logic [R-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [R-1:0]   gnt,
  output logic [IDW-1:0] gnt_idx
);

  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;
  logic           found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < R; k++) begin
      // ptr + k taken modulo R with one conditional subtract, since both
      // operands are below R.
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(R)) sum = sum - (IDW+1)'(R);
      idx = sum[IDW-1:0];
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/diff_word_arb.sv
// diff_word_arb: shares one registered mod-4 differential word encoder
// among R requesters using round-robin arbitration.
//   clk, rst   - clock (rising edge), asynchronous active-high reset
//   req_valid  - per-requester word valid
//   req_ready  - per-requester accept strobe (one-hot or zero)
//   req_word   - requester r word at [r*2N +: 2N], digit i at [2i +: 2]
//   out_valid, out_ready, out_word, out_id - encoded result port
//   busy       - high whenever the FSM is not IDLE
//   dbg_state  - current FSM state, for observation only
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Requester side: ready is raised combinationally only for the
// granted valid requester while IDLE. Output side: once out_valid rises,
// out_word/out_id stay stable and out_valid stays high until out_ready.
module diff_word_arb
  import diff_pkg::*;
#(
  parameter int N   = 100,
  parameter int R   = 4,
  parameter int IDW = $clog2(R)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [R-1:0]     req_valid,
  output logic [R-1:0]     req_ready,
  input  logic [R*2*N-1:0] req_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   out_word,
  output logic [IDW-1:0]   out_id,
  output logic             busy,
  output arb_state_t       dbg_state
);

  arb_state_t     state_q;
  logic [IDW-1:0] ptr_q;
  logic [2*N-1:0] in_q;
  logic [IDW-1:0] id_q;
  logic           out_valid_q;
  logic [2*N-1:0] out_word_q;
  logic [IDW-1:0] out_id_q;

  logic [R-1:0]   gnt;
  logic [IDW-1:0] gnt_idx;
  logic [2*N-1:0] sel_word_d;
  logic [2*N-1:0] enc_word_d;

  // Arbitration only runs in IDLE, and never while reset is held, so
  // req_ready is guaranteed low during reset.
  rr_arbiter #(.R(R), .IDW(IDW)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .en      ((state_q == IDLE) && !rst),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // One-hot mux of the granted word.
  always_comb begin
    sel_word_d = '0;
    for (int r = 0; r < R; r++) begin
      if (gnt[r]) sel_word_d = req_word[r*2*N +: 2*N];
    end
  end

  // Differential encode: leftmost digit passes through, every other digit
  // is its difference from the digit to its left.
  always_comb begin
    enc_word_d = '0;
    enc_word_d[2*(N-1) +: 2] = in_q[2*(N-1) +: 2];
    for (int i = 0; i < N-1; i++) begin
      enc_word_d[2*i +: 2] = mod4_sub(in_q[2*i +: 2], in_q[2*(i+1) +: 2]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      in_q        <= '0;
      id_q        <= '0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_id_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|gnt) begin
            in_q    <= sel_word_d;
            id_q    <= gnt_idx;
            state_q <= ENC;
          end
        end
        ENC: begin
          out_word_q  <= enc_word_d;
          out_id_q    <= id_q;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            // The served requester drops to lowest priority next time.
            ptr_q   <= (id_q == IDW'(R-1)) ? '0 : IDW'(id_q + 1'b1);
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = gnt;
  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign out_id    = out_id_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_diff_word_arb.sv
module tb_diff_word_arb;
  import diff_pkg::*;

  localparam int N   = 4;
  localparam int R   = 4;
  localparam int IDW = 2;
  localparam int W   = IDW + 2*N;

  logic             clk;
  logic             rst;
  logic [R-1:0]     req_valid;
  logic [R-1:0]     req_ready;
  logic [R*2*N-1:0] req_word;
  logic             out_valid;
  logic             out_ready;
  logic [2*N-1:0]   out_word;
  logic [IDW-1:0]   out_id;
  logic             busy;
  arb_state_t       dbg_state;

  diff_word_arb #(.N(N), .R(R), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_word  (req_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_id    (out_id),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard & reference model ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];     // {id, encoded word} per accepted request
  int m_ptr   = 0;            // requester with top priority
  int m_phase = 0;            // 0 waiting, 1 encoding, 2 result presented
  int m_id    = 0;
  int cyc     = 0;
  int grant_log[$];
  int grant_cyc[$];

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*N-1:0] ref_diff(input logic [2*N-1:0] w);
    int d[N];
    logic [2*N-1:0] res;
    for (int i = 0; i < N; i++) d[i] = int'(w[2*i +: 2]);
    res = '0;
    res[2*(N-1) +: 2] = 2'(d[N-1]);
    for (int i = 0; i < N-1; i++) res[2*i +: 2] = 2'((d[i] - d[i+1] + 4) % 4);
    return res;
  endfunction

  function automatic int ref_pick(input logic [R-1:0] v, input int p);
    for (int k = 0; k < R; k++) begin
      if (v[(p + k) % R]) return (p + k) % R;
    end
    return -1;
  endfunction

  function automatic arb_state_t phase_state(input int p);
    case (p)
      1:       return ENC;
      2:       return DONE;
      default: return IDLE;
    endcase
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    m_phase = 0;
    exp_q.delete();
  endtask

  task automatic check_outputs();
    int g;
    logic [R-1:0] exp_rdy;
    exp_rdy = '0;
    if (m_phase == 0) begin
      g = ref_pick(req_valid, m_ptr);
      if (g >= 0) exp_rdy[g] = 1'b1;
    end
    check_eq("req_ready", req_ready, exp_rdy);
    check_eq("busy", busy, m_phase != 0);
    check_eq("out_valid", out_valid, m_phase == 2);
    check_eq("dbg_state", dbg_state, phase_state(m_phase));
    if (m_phase == 2) begin
      if (exp_q.size() == 0) check_eq("sb_empty", 1, 0);
      else check_eq("out_id_word", {out_id, out_word}, exp_q[0]);
    end
  endtask

  // Advances the model across one rising edge using the inputs that the
  // DUT sampled on that edge.
  task automatic model_update();
    int g;
    cyc++;
    case (m_phase)
      0: begin
        g = ref_pick(req_valid, m_ptr);
        if (g >= 0) begin
          exp_q.push_back({IDW'(g), ref_diff(req_word[g*2*N +: 2*N])});
          m_id = g;
          m_phase = 1;
          grant_log.push_back(g);
          grant_cyc.push_back(cyc);
        end
      end
      1: m_phase = 2;
      default: begin
        if (out_ready) begin
          void'(exp_q.pop_front());
          m_ptr = (m_id + 1) % R;
          m_phase = 0;
        end
      end
    endcase
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns at the next falling edge.
  task automatic drive_cycle(input logic [R-1:0] v, input logic rdy);
    req_valid = v;
    out_ready = rdy;
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check_eq({tag, "_out_valid"}, out_valid, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_out_word"}, out_word, 0);
    check_eq({tag, "_out_id"}, out_id, 0);
    check_eq({tag, "_req_ready"}, req_ready, 0);
    check_eq({tag, "_state"}, dbg_state, IDLE);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_lane(input int r, input logic [2*N-1:0] w);
    req_word[r*2*N +: 2*N] = w;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_word = '0;
    out_ready = 1'b0;
    @(negedge clk);
    req_valid = 4'b1111;
    do_reset("rst0");

    // Single requester: digits 3,1,0,2 encode to 3,2,3,2.
    set_lane(2, 8'hD2);
    drive_cycle(4'b0100, 1'b1);
    drive_cycle(4'b0000, 1'b1);
    check_eq("tp_word", out_word, 8'hEE);
    check_eq("tp_id", out_id, 2);
    drive_cycle(4'b0000, 1'b1);

    // Borrow wrap: digits 0,3,3,0 encode to 0,3,0,1.
    set_lane(0, 8'h3C);
    drive_cycle(4'b0001, 1'b1);
    drive_cycle(4'b0000, 1'b1);
    check_eq("wrap_word", out_word, 8'h31);
    drive_cycle(4'b0000, 1'b1);

    // Round robin with every line requesting.
    do_reset("rst_rr");
    grant_log.delete();
    grant_cyc.delete();
    for (int r = 0; r < R; r++) set_lane(r, 8'(r * 8'h47 + 8'h15));
    for (int k = 0; k < 15; k++) drive_cycle(4'b1111, 1'b1);
    check_eq("rr_count", grant_log.size() >= 5, 1);
    for (int k = 0; k < 5 && k < grant_log.size(); k++) begin
      check_eq("rr_order", grant_log[k], k % R);
      if (k > 0) check_eq("rr_spacing", grant_cyc[k] - grant_cyc[k-1], 3);
    end
    while (m_phase != 0) drive_cycle(4'b0000, 1'b1);

    // Backpressure: result must hold for 10 cycles with out_ready low.
    set_lane(1, 8'h9B);
    drive_cycle(4'b0010, 1'b0);
    drive_cycle(4'b1111, 1'b0);
    for (int k = 0; k < 10; k++) begin
      check_eq("bp_valid", out_valid, 1);
      drive_cycle(4'b1111, 1'b0);
    end
    check_eq("bp_done", dbg_state, DONE);
    drive_cycle(4'b1111, 1'b1);
    check_eq("bp_idle", dbg_state, IDLE);
    drive_cycle(4'b1111, 1'b1);
    check_eq("bp_regrant", busy, 1);
    while (m_phase != 0) drive_cycle(4'b0000, 1'b1);

    // Priority rotation: after serving 3, requester 0 beats 3.
    do_reset("rst_rot");
    drive_cycle(4'b1000, 1'b1);
    while (m_phase != 0) drive_cycle(4'b0000, 1'b1);
    grant_log.delete();
    for (int k = 0; k < 6; k++) drive_cycle(4'b1001, 1'b1);
    check_eq("rot_count", grant_log.size() >= 2, 1);
    if (grant_log.size() >= 2) begin
      check_eq("rot_first", grant_log[0], 0);
      check_eq("rot_second", grant_log[1], 3);
    end
    while (m_phase != 0) drive_cycle(4'b0000, 1'b1);

    // Reset while encoding.
    drive_cycle(4'b0100, 1'b1);
    check_eq("mid_enc_state", dbg_state, ENC);
    req_valid = 4'b0010;
    do_reset("rst_enc");
    grant_log.delete();
    drive_cycle(4'b0010, 1'b0);
    check_eq("enc_regrant", grant_log.size() == 1 && grant_log[0] == 1, 1);

    // Reset while presenting the result.
    drive_cycle(4'b0000, 1'b0);
    drive_cycle(4'b0000, 1'b0);
    check_eq("mid_done_state", dbg_state, DONE);
    req_valid = 4'b0010;
    do_reset("rst_done");
    grant_log.delete();
    drive_cycle(4'b0010, 1'b1);
    check_eq("done_regrant", grant_log.size() == 1 && grant_log[0] == 1, 1);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      for (int r = 0; r < R; r++) set_lane(r, 8'($urandom));
      drive_cycle(4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Backstop so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/diff_word_arb.md
# diff_word_arb

Round-robin scheduler that shares one differential DNA-word encoder among R requesters. Each requester presents an N-digit word (2 bits per digit) with a valid/ready handshake. The arbiter grants one requester at a time and runs the word through the registered mod-4 differential encode. It returns the result with the requester's ID on a single valid/ready output port. The block sits between the per-lane word producers and the downstream channel-encoding stage.

## Interface
- N, 100, digits per word
- R, 4, number of requesters (R >= 2)
- IDW, $clog2(R), width of requester ID
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  R  per-requester word valid
- req_ready  out  R  per-requester accept strobe, one-hot or zero
- req_word  in  R*2N  requester r word at [r*2N +: 2N]; digit i at [2i +: 2]; digit N-1 is leftmost
- out_valid  out  1  encoded word available
- out_ready  in  1  downstream accepts
- out_word  out  2N  differential word
- out_id  out  IDW  index of requester that produced out_word
- busy  out  1  high whenever state != IDLE

## Operation
- The FSM has three states: IDLE, ENC and DONE.
- IDLE:
  - The grant index g is the first r with req_valid[r]=1, searching ptr, ptr+1, … R-1, 0, … ptr-1.
  - req_ready[g]=1 combinationally in the same cycle.
  - On that edge, capture in_reg <= req_word[g] and id_reg <= g, then go to ENC.
  - No request valid: stay in IDLE with req_ready=0.
- ENC:
  - out_word <= diff(in_reg), out_id <= id_reg, out_valid <= 1, then go to DONE.
  - req_ready=0.
- DONE:
  - out_word, out_id and out_valid are held stable.
  - On out_valid && out_ready: out_valid <= 0, ptr <= (id_reg+1) mod R, go to IDLE.
  - req_ready=0.
- Differential rule:
  - Output digit N-1 equals input digit N-1.
  - For i = N-2..0, output digit i = (in[i] - in[i+1]) mod 4.
  - Compute the difference in 3 bits and keep the low 2 bits; no saturation. For example, 0-3 -> 1 and 1-3 -> 2.
- Fairness: the last-served requester has lowest priority in the next arbitration. Any requester that keeps req_valid asserted is served within R transactions.
- req_valid dropping while that requester has not been granted is legal. Its word is not captured.
- req_word is sampled only on the grant edge and may change afterwards.

## Timing
- Reset values:
  - state=IDLE, ptr=0
  - out_valid=0, out_word=0, out_id=0
  - in_reg=0, id_reg=0
  - busy=0
  - req_ready=0 (forced 0 while rst=1)
- Latency: grant at edge T, then out_valid=1 after edge T+1.
- The earliest next grant is the cycle after the out handshake. Peak throughput is one word per 3 cycles.
- out_ready asserted in advance of out_valid: the handshake completes in the first DONE cycle.
- Reset mid-operation, in any state: all registers return to reset values immediately. Any in-flight word is dropped without an output, and ptr returns to 0.
- Simultaneous req_valid on all R lines: exactly one req_ready bit is high. The others wait in IDLE on later passes.
- ptr wrap: after serving requester R-1, ptr=0.

## Structure
- Shared package diff_pkg holds:
  - typedef digit_t (logic [1:0])
  - the enum arb_state_t {IDLE, ENC, DONE}
  - function mod4_sub(cur, prev) returning digit_t
- Sub-module rr_arbiter, parameter R:
  - Inputs: req[R], ptr[IDW], en.
  - Outputs: one-hot gnt[R] and gnt_idx[IDW].
  - Purely combinational, reusable by other shared-resource blocks.
- The top level holds the FSM, ptr, in_reg/id_reg, the encode loop and the output registers.

## Test plan
- Single requester, N=4, R=4:
  - Stimulus: req_valid=4'b0100, word 8'hD2 (digits 3,1,0,2).
  - Required: req_ready=4'b0100 for one cycle; after 2 edges out_valid=1, out_word=8'hEE (digits 3,2,3,2), out_id=2.
- Wrap arithmetic, N=4:
  - Stimulus: word 8'h3C (digits 0,3,3,0).
  - Required: out_word digits 0,3,0,1 = 8'h31.
- Round-robin:
  - Stimulus: all 4 req_valid held high with out_ready=1.
  - Required: grant order 0,1,2,3,0, each output carrying the matching out_id; a new grant every 3 cycles.
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles after out_valid rises.
  - Required: out_word/out_id stable, busy=1, all req_ready=0; one cycle after out_ready=1, state is IDLE and the next grant is possible.
- Priority rotation:
  - Stimulus: serve requester 3, then assert req_valid=4'b1001.
  - Required: requester 0 granted (ptr wrapped to 0), then requester 3.
- Reset mid-operation:
  - Stimulus: assert rst during ENC, and separately during DONE.
  - Required: out_valid=0, busy=0, out_word=0 asynchronously; after release with req_valid=4'b0010, requester 1 is granted (ptr=0 search).
